// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode/state encodings and default sizing for seq_alu.
// Used by seq_alu and seq_alu_muldiv; divider build selected by SEQ_ALU_DIV_EN.
package seq_alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int OPW_DEF   = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_SHR = 4'd2,
        OP_SHL = 4'd3,
        OP_ROR = 4'd4,
        OP_ROL = 4'd5,
        OP_AND = 4'd6,
        OP_OR  = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9,
        OP_NEG = 4'd10,
        OP_NOT = 4'd11
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: WIDTH-step signed Booth multiplier and, with SEQ_ALU_DIV_EN,
// a signed restoring divider sharing the same shift registers.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ZHI,
    output logic [WIDTH-1:0] ZLO,
    output logic             dz,
    output logic             fin
);

    localparam int            CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH);

    logic [OPW+3:0]   op_ext;
    logic             op_hi;
    logic             is_mul_op;
    logic             load;
    logic [WIDTH:0]   acc, acc_n, mcand, booth_sum;
    logic [WIDTH-1:0] mq, mq_n;
    logic             q_1;
    logic [CW-1:0]    cnt;
    logic             active;

    assign op_ext    = {4'b0000, op};
    assign op_hi     = |op_ext[OPW+3:4];
    assign is_mul_op = (op_ext[3:0] == OP_MUL) && !op_hi;

`ifdef SEQ_ALU_DIV_EN
    logic             is_div_op;
    logic             div_mode, a_neg, q_neg, dz_r;
    logic [WIDTH-1:0] a_save, a_abs, b_abs;
    logic [WIDTH:0]   div_shift, div_trial;

    assign is_div_op = (op_ext[3:0] == OP_DIV) && !op_hi;
    assign load      = start && (is_mul_op || is_div_op);
    assign a_abs     = A[WIDTH-1] ? -A : A;
    assign b_abs     = B[WIDTH-1] ? -B : B;
    assign div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign div_trial = div_shift - mcand;
`else
    assign load = start && is_mul_op;
`endif

    // acc is one bit wider than the operands so that subtracting the most
    // negative multiplicand cannot overflow.
    always_comb begin
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mq_n  = {booth_sum[0], mq[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        if (div_mode) begin
            if (div_trial[WIDTH]) begin
                acc_n = div_shift;
                mq_n  = {mq[WIDTH-2:0], 1'b0};
            end else begin
                acc_n = div_trial;
                mq_n  = {mq[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc    <= '0;
            mq     <= '0;
            mcand  <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            active <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_mode <= 1'b0;
            a_neg    <= 1'b0;
            q_neg    <= 1'b0;
            dz_r     <= 1'b0;
            a_save   <= '0;
`endif
        end else if (load) begin
            active <= 1'b1;
            cnt    <= STEPS;
            acc    <= '0;
            q_1    <= 1'b0;
            mq     <= A;
            mcand  <= {B[WIDTH-1], B};
`ifdef SEQ_ALU_DIV_EN
            div_mode <= is_div_op;
            a_neg    <= A[WIDTH-1];
            q_neg    <= A[WIDTH-1] ^ B[WIDTH-1];
            dz_r     <= (B == '0);
            a_save   <= A;
            if (is_div_op) begin
                mq    <= a_abs;
                mcand <= {1'b0, b_abs};
            end
`endif
        end else if (active) begin
            if (cnt != '0) begin
                acc <= acc_n;
                mq  <= mq_n;
                q_1 <= mq[0];
                cnt <= cnt - CW'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign fin = active && (cnt == '0);

`ifdef SEQ_ALU_DIV_EN
    always_comb begin
        ZHI = acc[WIDTH-1:0];
        ZLO = mq;
        dz  = 1'b0;
        if (div_mode) begin
            if (dz_r) begin
                ZHI = a_save;
                ZLO = '1;
                dz  = 1'b1;
            end else begin
                ZHI = a_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                ZLO = q_neg ? -mq : mq;
            end
        end
    end
`else
    assign ZHI = acc[WIDTH-1:0];
    assign ZLO = mq;
    assign dz  = 1'b0;
`endif

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU top -- control FSM, single-cycle ops, result registers.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise op 9 reports err.
//
//   state  | meaning
//   IDLE   | waiting for start, operands captured on start
//   EXEC   | single-cycle result computed, or mul/div handed to muldiv
//   ITER   | muldiv stepping, WIDTH cycles
//   DONE   | done pulse, results registered
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ZHI,
    output logic [WIDTH-1:0] ZLO,
    output logic             err
);

    localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);
`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    function automatic logic iter_op(input logic [OPW-1:0] code);
        logic [OPW+3:0] ext;
        ext = {4'b0000, code};
        return !(|ext[OPW+3:4]) &&
               ((ext[3:0] == OP_MUL) || (DIV_EN && (ext[3:0] == OP_DIV)));
    endfunction

    state_t           state;
    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [OPW+3:0]   opr_ext;
    logic             opr_hi;
    logic [WIDTH-1:0] sc_res, rot_amt, rol_amt;
    logic             sc_err;
    logic             md_start, md_dz, md_fin;
    logic [WIDTH-1:0] md_zhi, md_zlo;

    assign opr_ext  = {4'b0000, op_r};
    assign opr_hi   = |opr_ext[OPW+3:4];
    assign md_start = (state == S_IDLE) && start && iter_op(op);

    always_comb begin
        sc_res  = '0;
        sc_err  = 1'b0;
        rot_amt = b_r % WVAL;
        rol_amt = (rot_amt == '0) ? '0 : WVAL - rot_amt;
        if (opr_hi) begin
            sc_err = 1'b1;
        end else begin
            case (opr_ext[3:0])
                OP_ADD:  sc_res = a_r + b_r;
                OP_SUB:  sc_res = a_r - b_r;
                OP_SHR:  sc_res = (b_r >= WVAL) ? '0 : a_r >> b_r;
                OP_SHL:  sc_res = (b_r >= WVAL) ? '0 : a_r << b_r;
                OP_ROR:  sc_res = WIDTH'({a_r, a_r} >> rot_amt);
                OP_ROL:  sc_res = WIDTH'({a_r, a_r} >> rol_amt);
                OP_AND:  sc_res = a_r & b_r;
                OP_OR:   sc_res = a_r | b_r;
                OP_NEG:  sc_res = -a_r;
                OP_NOT:  sc_res = ~a_r;
                default: sc_err = 1'b1;
            endcase
        end
    end

    seq_alu_muldiv #(
        .WIDTH(WIDTH),
        .OPW  (OPW)
    ) u_muldiv (
        .clock(clock),
        .clear(clear),
        .start(md_start),
        .op   (op),
        .A    (A),
        .B    (B),
        .ZHI  (md_zhi),
        .ZLO  (md_zlo),
        .dz   (md_dz),
        .fin  (md_fin)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            ZHI   <= '0;
            ZLO   <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= A;
                        b_r   <= B;
                        busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (iter_op(op_r)) begin
                        state <= S_ITER;
                    end else begin
                        ZHI   <= '0;
                        ZLO   <= sc_res;
                        err   <= sc_err;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_ITER: begin
                    if (md_fin) begin
                        ZHI   <= md_zhi;
                        ZLO   <= md_zlo;
                        err   <= md_dz;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu at WIDTH=32 with hand-computed results.
// Expectations for op 9 follow whether SEQ_ALU_DIV_EN is defined.
module tb_seq_alu;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy, done, err;
    logic [31:0] ZHI, ZLO;

    int n_chk = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(32), .OPW(4)) dut (
        .clock(clock),
        .clear(clear),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .ZHI  (ZHI),
        .ZLO  (ZLO),
        .err  (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; cyc counts edges since then.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic op_run(input string tag, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic eerr, input int elat);
        int cyc;
        issue(o, a, b);
        wait_done(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(elat));
        check({tag, "_lo"}, 64'(ZLO), 64'(elo));
        check({tag, "_hi"}, 64'(ZHI), 64'(ehi));
        check({tag, "_err"}, 64'(err), 64'(eerr));
        @(posedge clock);
        #1;
        check({tag, "_idle"}, 64'({busy, done}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int extra;
        clear = 1'b1;
        start = 1'b0;
        op    = '0;
        A     = '0;
        B     = '0;
        #2;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err",  64'(err),  64'(0));
        check("rst_zlo",  64'(ZLO),  64'(0));
        check("rst_zhi",  64'(ZHI),  64'(0));
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;

        op_run("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'h1,          32'h0, 32'h0000_0000, 1'b0, 2);
        op_run("sub",       4'd1,  32'h5,         32'h7,          32'h0, 32'hFFFF_FFFE, 1'b0, 2);
        op_run("shr",       4'd2,  32'h8000_0000, 32'h4,          32'h0, 32'h0800_0000, 1'b0, 2);
        op_run("shr_32",    4'd2,  32'hFFFF_FFFF, 32'd32,         32'h0, 32'h0,         1'b0, 2);
        op_run("shl",       4'd3,  32'h1,         32'd31,         32'h0, 32'h8000_0000, 1'b0, 2);
        op_run("shl_32",    4'd3,  32'hFFFF_FFFF, 32'd32,         32'h0, 32'h0,         1'b0, 2);
        op_run("ror1",      4'd4,  32'h1,         32'd1,          32'h0, 32'h8000_0000, 1'b0, 2);
        op_run("ror32",     4'd4,  32'h1234_5678, 32'd32,         32'h0, 32'h1234_5678, 1'b0, 2);
        op_run("rol33",     4'd5,  32'h8000_0001, 32'd33,         32'h0, 32'h0000_0003, 1'b0, 2);
        op_run("rol4",      4'd5,  32'h1234_5678, 32'd4,          32'h0, 32'h2345_6781, 1'b0, 2);
        op_run("and",       4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0, 32'hF000_F000, 1'b0, 2);
        repeat (3) @(posedge clock);
        #1;
        check("hold_lo", 64'(ZLO), 64'(32'hF000_F000));
        op_run("or",        4'd7,  32'hF0F0_F0F0, 32'h0F00_0F00,  32'h0, 32'hFFF0_FFF0, 1'b0, 2);
        op_run("neg",       4'd10, 32'h1,         32'h0,          32'h0, 32'hFFFF_FFFF, 1'b0, 2);
        op_run("not",       4'd11, 32'h0000_FFFF, 32'h0,          32'h0, 32'hFFFF_0000, 1'b0, 2);
        op_run("ill12",     4'd12, 32'h5,         32'h5,          32'h0, 32'h0,         1'b1, 2);
        op_run("ill15",     4'd15, 32'hFFFF_FFFF, 32'h1,          32'h0, 32'h0,         1'b1, 2);
        op_run("mul_neg",   4'd8,  32'hFFFF_FFFD, 32'h7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        op_run("mul_minmin",4'd8,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0,         1'b0, 34);
        op_run("mul_max",   4'd8,  32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 34);
        op_run("mul_negneg",4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFE,  32'h0, 32'h0000_0002, 1'b0, 34);
`ifdef SEQ_ALU_DIV_EN
        op_run("div_neg",   4'd9,  32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        op_run("div_negb",  4'd9,  32'h7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
        op_run("div_zero",  4'd9,  32'h1234_5678, 32'h0,          32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 34);
        op_run("div_ovf",   4'd9,  32'h8000_0000, 32'hFFFF_FFFF,  32'h0, 32'h8000_0000, 1'b0, 34);
        op_run("div_pos",   4'd9,  32'd100,       32'd7,          32'd2, 32'd14,        1'b0, 34);
`else
        op_run("div_off",   4'd9,  32'h10,        32'h2,          32'h0, 32'h0,         1'b1, 2);
`endif

        // second start during ITER must be ignored and not queued
        issue(4'd8, 32'd3, 32'd5);
        cyc = 1;
        repeat (4) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        @(negedge clock);
        op    = 4'd0;
        A     = 32'd1;
        B     = 32'd1;
        start = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
        start = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("busy_ign_lat", 64'(cyc), 64'(34));
        check("busy_ign_lo",  64'(ZLO), 64'(32'd15));
        check("busy_ign_hi",  64'(ZHI), 64'(0));
        extra = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (done) extra++;
        end
        check("busy_ign_nodone", 64'(extra), 64'(0));

        // clear mid-ITER aborts; start held through clear is taken on the first edge after release
        issue(4'd8, 32'h1234, 32'h10);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("pre_clr_busy", 64'(busy), 64'(1));
        #2;
        clear = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'(0));
        check("clr_done", 64'(done), 64'(0));
        check("clr_zlo",  64'(ZLO),  64'(0));
        check("clr_zhi",  64'(ZHI),  64'(0));
        check("clr_err",  64'(err),  64'(0));
        op    = 4'd0;
        A     = 32'd2;
        B     = 32'd3;
        start = 1'b1;
        @(posedge clock);
        #1;
        check("clr_hold_busy", 64'(busy), 64'(0));
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(cyc);
        check("post_clr_lat", 64'(cyc), 64'(2));
        check("post_clr_lo",  64'(ZLO), 64'(32'd5));
        check("post_clr_err", 64'(err), 64'(0));
        extra = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) extra++;
        end
        check("post_clr_nodone", 64'(extra), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
